fu_sequencer: RTL and testbench

Single-thread instruction sequencer for one `func_unit` lane. On `start` it loads the lane's register file, then fetches 32-bit instructions from a synchronous instruction memory. It decodes each instruction and issues it to the functional unit for exactly one cycle, inserting a safe bubble between issues. It stops at the first RETURN (3'b111) and reports completion or a PC-overflow error to the warp-level scheduler above it.

---
 rtl/fu_sequencer_if.sv | 44 ++++
 rtl/fu_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_sequencer_if.sv
// -----------------------------------------------------------------------------
// fu_sequencer_if
//   Bus bundle between the sequencer, its synchronous instruction memory and
//   the func_unit lane it drives.
//
//   Parameters
//     PC_W        instruction address width
//   Signals
//     imem_rd_en  instruction memory read strobe
//     imem_addr   instruction memory address
//     imem_rdata  instruction word, valid the cycle after imem_rd_en
//     fu_type     -> type_instruction (3'b111 = RETURN / bubble)
//     fu_rs1      -> regnum_1
//     fu_rs2      -> regnum_2
//     fu_rd       -> dest_reg
//     fu_shamt    -> shammt
//   Modports
//     master      sequencer side
//     slave       memory / functional-unit side
// -----------------------------------------------------------------------------
interface fu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_rd_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [2:0]      fu_type;
    logic [4:0]      fu_rs1;
    logic [4:0]      fu_rs2;
    logic [4:0]      fu_rd;
    logic [5:0]      fu_shamt;

    modport master (
        output imem_rd_en, imem_addr,
        output fu_type, fu_rs1, fu_rs2, fu_rd, fu_shamt,
        input  imem_rdata
    );

    modport slave (
        input  imem_rd_en, imem_addr,
        input  fu_type, fu_rs1, fu_rs2, fu_rd, fu_shamt,
        output imem_rdata
    );
endinterface

// File: rtl/fu_sequencer.sv
// -----------------------------------------------------------------------------
// fu_sequencer
//   Single-thread instruction sequencer for one func_unit lane. On start it
//   issues a register-file LOAD, then alternates FETCH / ISSUE over a
//   synchronous instruction memory until the first RETURN (3'b111) or until
//   the PC would run past the top of program space (sticky err, no wrap).
//   Between issues the fu_* outputs carry a bubble (type 3'b111, all fields 0)
//   so the unit never sees a spurious register write.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous-assert reset, active low
//     start        launch request, sampled only in IDLE
//     start_pc     first instruction address, captured with start
//     bus          fu_sequencer_if.master (imem read port + fu issue port)
//     busy         high from the cycle after an accepted start until DONE exits
//     done         one-cycle pulse on the DONE cycle
//     err          sticky PC-overflow flag, cleared by the next accepted start
//     pc           current fetch address
//
//   Optional feature (macro FU_SEQ_PERF_EN)
//     perf_cycles  cycles spent busy in the current/last run (saturating)
//     perf_instrs  ISSUE cycles in the current/last run, RETURN included
// -----------------------------------------------------------------------------
module fu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    fu_sequencer_if.master  bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [PC_W-1:0] pc
`ifdef FU_SEQ_PERF_EN
    ,
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_instrs
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [2:0] TYPE_LOAD = 3'b110;
    localparam logic [2:0] TYPE_RET  = 3'b111;

    state_t     state;
    logic [2:0] rd_type;

    assign rd_type       = bus.imem_rdata[31:29];
    assign bus.imem_addr = pc;

    // Issue port: bubble everywhere except LOAD and ISSUE. In ISSUE the word
    // read during FETCH is forwarded combinationally, so an async reset in
    // ISSUE drops straight back to the bubble.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        bus.fu_type  = TYPE_RET;
        bus.fu_rs1   = '0;
        bus.fu_rs2   = '0;
        bus.fu_rd    = '0;
        bus.fu_shamt = '0;
        case (state)
            S_LOAD: bus.fu_type = TYPE_LOAD;
            S_ISSUE: begin
                bus.fu_type  = rd_type;
                bus.fu_rs1   = bus.imem_rdata[28:24];
                bus.fu_rs2   = bus.imem_rdata[23:19];
                bus.fu_rd    = bus.imem_rdata[18:14];
                bus.fu_shamt = bus.imem_rdata[13:8];
            end
            default: ;
        endcase
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            pc             <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            bus.imem_rd_en <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees
            // the pre-edge values of state, pc and friends.
            done           <= 1'b0;
            bus.imem_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= start_pc;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bus.imem_rd_en <= 1'b1;
                    state          <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (rd_type == TYPE_RET) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (pc == '1) begin
                        // Last word of program space was not a RETURN:
                        // flag it and stop rather than wrap to 0.
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        pc             <= pc + 1'b1;
                        bus.imem_rd_en <= 1'b1;
                        state          <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FU_SEQ_PERF_EN
    // Saturating run counters; cleared by an accepted start, frozen in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_instrs <= '0;
        end else if (state == S_IDLE && start) begin
            perf_cycles <= '0;
            perf_instrs <= '0;
        end else begin
            if (busy && perf_cycles != '1)
                perf_cycles <= perf_cycles + 32'd1;
            if (state == S_ISSUE && perf_instrs != '1)
                perf_instrs <= perf_instrs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fu_sequencer
//   Directed bench for fu_sequencer. Two instances share clk/rst: one with the
//   default PC_W=8 for the normal programs and one with PC_W=4 for the
//   top-of-program-space case. Each has a small synchronous instruction memory
//   that returns junk whenever it was not read the cycle before. Outputs are
//   sampled on the falling edge; "cycle k" is the cycle after the k-th rising
//   edge following the start edge (edge 0).
//   Build with +define+FU_SEQ_PERF_EN to cover the performance counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUT with PC_W = 8 ----------------
    logic       start8    = 1'b0;
    logic [7:0] start_pc8 = '0;
    logic       busy8, done8, err8;
    logic [7:0] pc8;
    logic [31:0] mem8 [256];

    fu_sequencer_if #(.PC_W(8)) bus8 ();

`ifdef FU_SEQ_PERF_EN
    logic [31:0] perf_cycles8, perf_instrs8, perf_cycles4, perf_instrs4;
`endif

    fu_sequencer #(.PC_W(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .start_pc (start_pc8),
        .bus      (bus8.master),
        .busy     (busy8),
        .done     (done8),
        .err      (err8),
        .pc       (pc8)
`ifdef FU_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles8),
        .perf_instrs (perf_instrs8)
`endif
    );

    always @(posedge clk)
        bus8.imem_rdata <= bus8.imem_rd_en ? mem8[bus8.imem_addr] : 32'h5A5A_5A5A;

    // ---------------- DUT with PC_W = 4 ----------------
    logic       start4    = 1'b0;
    logic [3:0] start_pc4 = '0;
    logic       busy4, done4, err4;
    logic [3:0] pc4;
    logic [31:0] mem4 [16];

    fu_sequencer_if #(.PC_W(4)) bus4 ();

    fu_sequencer #(.PC_W(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .start_pc (start_pc4),
        .bus      (bus4.master),
        .busy     (busy4),
        .done     (done4),
        .err      (err4),
        .pc       (pc4)
`ifdef FU_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles4),
        .perf_instrs (perf_instrs4)
`endif
    );

    always @(posedge clk)
        bus4.imem_rdata <= bus4.imem_rd_en ? mem4[bus4.imem_addr] : 32'hA5A5_A5A5;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected fu port as one vector {type, rs1, rs2, rd, shamt}.
    function automatic logic [23:0] fv(input logic [2:0] t, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d,
                                       input logic [5:0] s);
        return {t, a, b, d, s};
    endfunction

    // Instruction word; the ignored low byte is deliberately non-zero.
    function automatic logic [31:0] instr(input logic [2:0] t, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] d,
                                          input logic [5:0] s);
        return {t, a, b, d, s, 8'hC3};
    endfunction

    localparam logic [23:0] BUB   = 24'hE0_0000;   // type 111, all fields 0
    localparam logic [23:0] FLOAD = 24'hC0_0000;   // type 110, all fields 0

    task automatic expect8(input string tag, input logic [23:0] fu, input logic rd_en,
                           input logic busy, input logic done, input logic err,
                           input logic [7:0] pc);
        check({tag, ".fu"},   {bus8.fu_type, bus8.fu_rs1, bus8.fu_rs2, bus8.fu_rd, bus8.fu_shamt}, fu);
        check({tag, ".rden"}, bus8.imem_rd_en, rd_en);
        check({tag, ".busy"}, busy8, busy);
        check({tag, ".done"}, done8, done);
        check({tag, ".err"},  err8, err);
        check({tag, ".pc"},   pc8, pc);
    endtask

    task automatic expect4(input string tag, input logic [23:0] fu, input logic rd_en,
                           input logic busy, input logic done, input logic err,
                           input logic [3:0] pc);
        check({tag, ".fu"},   {bus4.fu_type, bus4.fu_rs1, bus4.fu_rs2, bus4.fu_rd, bus4.fu_shamt}, fu);
        check({tag, ".rden"}, bus4.imem_rd_en, rd_en);
        check({tag, ".busy"}, busy4, busy);
        check({tag, ".done"}, done4, done);
        check({tag, ".err"},  err4, err);
        check({tag, ".pc"},   pc4, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge of cycle 1.
    task automatic launch8(input logic [7:0] spc);
        start8    = 1'b1;
        start_pc8 = spc;
        tick();
        start8    = 1'b0;
    endtask

    task automatic launch4(input logic [3:0] spc);
        start4    = 1'b1;
        start_pc4 = spc;
        tick();
        start4    = 1'b0;
    endtask

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem8[i] = instr(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
        for (int i = 0; i < 16; i++)  mem4[i] = instr(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);

        // Basic program: ADD r3,r1,r2 ; RETURN
        mem8[8'h10] = instr(3'b000, 5'd1, 5'd2, 5'd3, 6'd0);
        mem8[8'h11] = {3'b111, 29'd0};
        mem8[8'h12] = instr(3'b011, 5'd9, 5'd9, 5'd9, 6'd9);
        // LOAD in the stream, a shift with max shamt, RETURN
        mem8[8'h20] = instr(3'b110, 5'd0, 5'd0, 5'd7, 6'd0);
        mem8[8'h21] = instr(3'b010, 5'd8, 5'd9, 5'd10, 6'd63);
        mem8[8'h22] = {3'b111, 29'd0};
        // PC_W=4: SUB at the last word; RETURN at word 2
        mem4[15] = instr(3'b001, 5'd4, 5'd5, 5'd6, 6'd5);
        mem4[0]  = instr(3'b011, 5'd1, 5'd1, 5'd1, 6'd1);
        mem4[2]  = {3'b111, 29'd0};

        // ---- reset: asserted before any clock edge ----
        #1 rst = 1'b0;
        #1;
        expect8("rst8", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect4("rst4", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect8("idle8", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // ---- basic program ----
        launch8(8'h10);
        expect8("b1", FLOAD, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        tick();
        expect8("b2", BUB, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        check("b2.addr", bus8.imem_addr, 8'h10);
        tick();
        expect8("b3", fv(3'b000, 5'd1, 5'd2, 5'd3, 6'd0), 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        tick();
        expect8("b4", BUB, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        check("b4.addr", bus8.imem_addr, 8'h11);
        tick();
        expect8("b5", fv(3'b111, 5'd0, 5'd0, 5'd0, 6'd0), 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        tick();
        expect8("b6", BUB, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
        tick();
        expect8("b7", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11);
`ifdef FU_SEQ_PERF_EN
        check("b.perf_instrs", perf_instrs8, 32'd2);
        check("b.perf_cycles", perf_cycles8, 32'd6);
`endif

        // ---- LOAD issued from the stream; perf counters over 3 instructions ----
        tick();
        launch8(8'h20);
        expect8("p1", FLOAD, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
`ifdef FU_SEQ_PERF_EN
        check("p1.perf_instrs", perf_instrs8, 32'd0);
        check("p1.perf_cycles", perf_cycles8, 32'd0);
`endif
        tick();
        expect8("p2", BUB, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        tick();
        expect8("p3", fv(3'b110, 5'd0, 5'd0, 5'd7, 6'd0), 1'b0, 1'b1, 1'b0, 1'b0, 8'h20);
        tick();
        expect8("p4", BUB, 1'b1, 1'b1, 1'b0, 1'b0, 8'h21);
        tick();
        expect8("p5", fv(3'b010, 5'd8, 5'd9, 5'd10, 6'd63), 1'b0, 1'b1, 1'b0, 1'b0, 8'h21);
        tick();
        expect8("p6", BUB, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        tick();
        expect8("p7", fv(3'b111, 5'd0, 5'd0, 5'd0, 6'd0), 1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
        tick();
        expect8("p8", BUB, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22);
        tick();
        expect8("p9", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22);
`ifdef FU_SEQ_PERF_EN
        check("p9.perf_instrs", perf_instrs8, 32'd3);
        check("p9.perf_cycles", perf_cycles8, 32'd8);
        tick();
        check("p10.perf_instrs_hold", perf_instrs8, 32'd3);
        check("p10.perf_cycles_hold", perf_cycles8, 32'd8);
`endif

        // ---- overflow at the top of a 16-word program space ----
        launch4(4'd15);
        expect4("o1", FLOAD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
        tick();
        expect4("o2", BUB, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15);
        check("o2.addr", bus4.imem_addr, 4'd15);
        tick();
        expect4("o3", fv(3'b001, 5'd4, 5'd5, 5'd6, 6'd5), 1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
        tick();
        expect4("o4", BUB, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15);
        tick();
        expect4("o5", BUB, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        tick();
        expect4("o6", BUB, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15);

        // ---- new start clears err; start during FETCH is ignored ----
        launch4(4'd2);
        expect4("s1", FLOAD, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        tick();
        expect4("s2", BUB, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
        start4    = 1'b1;
        start_pc4 = 4'd9;
        tick();
        start4    = 1'b0;
        expect4("s3", fv(3'b111, 5'd0, 5'd0, 5'd0, 6'd0), 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        tick();
        expect4("s4", BUB, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        tick();
        expect4("s5", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        tick();
        expect4("s6", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

        // ---- async reset during ISSUE ----
        launch8(8'h10);
        tick();
        tick();
        check("r3.issue_type", bus8.fu_type, 3'b000);
        #1 rst = 1'b0;
        #1;
        expect8("r_async", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        expect8("r_held", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        expect8("r_idle1", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        expect8("r_idle2", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect4("r_idle4", BUB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
